// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the tinyalu block: opcode and FSM encodings,
// multiply latency, and the single-cycle operation function.
package tinyalu_pkg;

  localparam int unsigned MUL_LAT = 3;

  // The multiplier sub-block supplies MUL_LAT-1 register stages; the top's
  // result register is the final stage of the multiply pipeline.
  localparam int unsigned MUL_PIPE_STAGES = MUL_LAT - 1;
  localparam logic [1:0]  MUL_LAST_CNT    = 2'(MUL_LAT - 2);

  typedef enum logic [2:0] {
    NO_OP  = 3'd0,
    ADD    = 3'd1,
    AND_OP = 3'd2,
    XOR_OP = 3'd3,
    MUL    = 3'd4,
    RSV5   = 3'd5,
    RSV6   = 3'd6,
    RSV7   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_e;

  function automatic logic [15:0] alu_calc(input op_e op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [15:0] prev);
    logic [15:0] r;
    case (op)
      ADD:     r = {7'd0, {1'b0, a} + {1'b0, b}};
      AND_OP:  r = {8'h00, a & b};
      XOR_OP:  r = {8'h00, a ^ b};
      default: r = prev;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tinyalu_mult.sv
// Registered 8x8 unsigned multiplier: stage one forms two nibble partial
// products, stage two sums them; valid travels alongside the data.
module tinyalu_mult
  import tinyalu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        in_valid,
  output logic [15:0] p,
  output logic        out_valid
);

  logic [11:0] lo_q, hi_q;
  logic [11:0] lo_d, hi_d;
  logic        s1_valid_q;
  logic [15:0] p_q, p_d;
  logic        p_valid_q;

  always_comb begin
    lo_d = 12'(a) * 12'(b[3:0]);
    hi_d = 12'(a) * 12'(b[7:4]);
    p_d  = 16'(lo_q) + {hi_q, 4'd0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q       <= 12'd0;
      hi_q       <= 12'd0;
      s1_valid_q <= 1'b0;
      p_q        <= 16'd0;
      p_valid_q  <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      p_valid_q  <= s1_valid_q;
      if (in_valid) begin
        lo_q <= lo_d;
        hi_q <= hi_d;
      end
      if (s1_valid_q) begin
        p_q <= p_d;
      end
    end
  end

  assign p         = p_q;
  assign out_valid = p_valid_q;

endmodule

// File: rtl/tinyalu.sv
// tinyalu top: start edge detect, control FSM, single-cycle ALU and the
// registered done/result outputs; multiply runs through tinyalu_mult.
module tinyalu
  import tinyalu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        start_q;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic        accept_s;
  logic        mul_start_s;
  logic [15:0] mul_p_s;
  logic        mul_valid_s;
  op_e         op_s;

  assign op_s     = op_e'(op);
  assign accept_s = start && !start_q;

  // Operands go straight into the multiplier on the accepting edge, which
  // is where they are latched; later input changes cannot reach the result.
  tinyalu_mult u_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (A),
    .b         (B),
    .in_valid  (mul_start_s),
    .p         (mul_p_s),
    .out_valid (mul_valid_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    result_d    = result_q;
    mul_start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (op_s == MUL) begin
            state_d     = MUL_BUSY;
            cnt_d       = 2'd0;
            mul_start_s = 1'b1;
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = alu_calc(op_s, A, B, result_q);
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL_BUSY: begin
        if (cnt_q == MUL_LAST_CNT) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = mul_valid_s ? mul_p_s : result_q;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_tinyalu.sv
// Directed self-checking bench for tinyalu: each vector carries its
// hand-computed result and done latency counted from the accept cycle.
module tb_tinyalu;

  logic        clk;
  logic        reset_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;

  int n_cmp;
  int n_bad;

  tinyalu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .op      (op),
    .start   (start),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise start at a negedge (accept cycle), count cycles to done, check
  // result, check the pulse ends, optionally hold start, then drop start.
  task automatic run_op(input string tag, input logic [2:0] opv, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input logic [15:0] exp_res,
                        input bit early_drop, input int hold);
    int n;
    int extra;
    bit got;
    @(negedge clk);
    A = a; B = b; op = opv; start = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        A = 8'h5A; B = 8'hA5;
        if (early_drop) start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_res"}, {16'd0, result}, {16'd0, exp_res});
    extra = 0;
    for (int i = 0; i < ((hold > 0) ? hold : 1); i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq({tag, "_pulse"}, extra, 0);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int extra;
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    A = 8'h00; B = 8'h00; op = 3'd0; start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", {16'd0, result}, 32'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("add_ff", 3'd1, 8'hFF, 8'hFF, 1, 16'h01FE, 1'b0, 0);
    run_op("noop",   3'd0, 8'h12, 8'h34, 1, 16'h01FE, 1'b0, 0);
    run_op("rsv7",   3'd7, 8'h56, 8'h78, 1, 16'h01FE, 1'b0, 0);
    run_op("and",    3'd2, 8'hF0, 8'h3C, 1, 16'h0030, 1'b0, 0);
    run_op("xor",    3'd3, 8'hAA, 8'hFF, 1, 16'h0055, 1'b0, 0);
    run_op("add_hold", 3'd1, 8'h80, 8'h90, 1, 16'h0110, 1'b0, 10);
    run_op("mul_ff", 3'd4, 8'hFF, 8'hFF, 3, 16'hFE01, 1'b0, 0);
    run_op("mul_cd", 3'd4, 8'h0C, 8'h0D, 3, 16'h009C, 1'b0, 0);
    run_op("mul_early", 3'd4, 8'h03, 8'h05, 3, 16'h000F, 1'b1, 0);

    // Abort a multiply with reset one cycle after it is accepted.
    @(negedge clk);
    A = 8'h11; B = 8'h11; op = 3'd4; start = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_result", {16'd0, result}, 32'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq("abort_no_done", extra, 0);
    check_eq("abort_result_hold", {16'd0, result}, 32'h0000);

    run_op("add_post", 3'd1, 8'h01, 8'h02, 1, 16'h0003, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
